// File: rtl/lif_pkg.sv
// lif_pkg: shared constants and helpers for the LIF grid cell.
// Holds default parameter values, the direct-hit bit index and the scatter pattern.
package lif_pkg;
  localparam int DIRS_D     = 4;
  localparam int POT_W_D    = 6;
  localparam int THRESH_D   = 3;
  localparam int LEAK_PER_D = 8;
  localparam int REFRACT_D  = 2;
  // Bit of the flattened input bus that carries neighbour d's head-on pulse.
  function automatic int direct_idx(int d, int dirs);
    return d * dirs + (d + dirs / 2) % dirs;
  endfunction
  // Scatter pattern, truncated to DIRS by the caller: odd or even directions set.
  function automatic logic [31:0] scatter(logic odd);
    return odd ? 32'hAAAA_AAAA : 32'h5555_5555;
  endfunction
endpackage

// File: rtl/lif_grid_cell_if.sv
// lif_grid_cell_if: neighbour bus of one grid cell.
// enable/in driven by the environment (master); out/fire/pot driven by the cell (slave).
interface lif_grid_cell_if
  import lif_pkg::*;
#(
  parameter int DIRS  = DIRS_D,
  parameter int POT_W = POT_W_D
);
  logic                 enable;
  logic [DIRS*DIRS-1:0] in;
  logic [DIRS-1:0]      out;
  logic                 fire;
  logic [POT_W-1:0]     pot;
  modport master(output enable, in, input out, fire, pot);
  modport slave(input enable, in, output out, fire, pot);
endinterface

// File: rtl/lfsr.sv
// lfsr: free-running 16-bit Fibonacci LFSR (taps 16,14,13,11).
// Ports: clk, reset (async, active-high), enable (advance), lfsr (current value).
module lfsr (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  output logic [15:0] lfsr
);
  localparam logic [15:0] SEED = 16'hACE1;
  logic w_fb;
  assign w_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  // All-zero is a lockup state; reseed so an unreset register still runs.
  always_ff @(posedge clk or posedge reset)
    if (reset) lfsr <= SEED;
    else if (enable) lfsr <= lfsr == '0 ? SEED : {lfsr[14:0], w_fb};
endmodule

// File: rtl/lif_grid_cell.sv
// lif_grid_cell: leaky integrate-and-fire cell with head-on pulse routing.
// Ports: clk, reset (async, active-high), bus (slave: enable, in, out, fire, pot).
module lif_grid_cell
  import lif_pkg::*;
#(
  parameter int DIRS     = DIRS_D,
  parameter int POT_W    = POT_W_D,
  parameter int THRESH   = THRESH_D,
  parameter int LEAK_PER = LEAK_PER_D,
  parameter int REFRACT  = REFRACT_D
) (
  input logic             clk,
  input logic             reset,
  lif_grid_cell_if.slave  bus
);
  localparam int CW  = $clog2(DIRS * DIRS) + 1;
  localparam int SW  = POT_W + CW;
  localparam int LW  = LEAK_PER > 1 ? $clog2(LEAK_PER) : 1;
  localparam int LP1 = LEAK_PER > 0 ? LEAK_PER - 1 : 0;
  localparam int RW  = REFRACT > 0 ? $clog2(REFRACT + 1) : 1;
  localparam logic [SW-1:0] PMAX = SW'({POT_W{1'b1}});
  logic [DIRS-1:0]      r_out;
  logic                 r_fire;
  logic [POT_W-1:0]     r_pot;
  logic [RW-1:0]        r_ref;
  logic [LW-1:0]        r_lk;
  logic [15:0]          w_rnd;
  logic                 w_unused;
  logic [DIRS*DIRS-1:0] w_dmask;
  logic [DIRS*DIRS-1:0] w_obl;
  logic [DIRS-1:0]      w_hit;
  logic [DIRS-1:0]      w_pri;
  logic [DIRS-1:0]      w_scat;
  logic [DIRS-1:0]      w_out;
  logic [DIRS/2-1:0]    w_col;
  logic [CW-1:0]        w_c;
  logic [CW-1:0]        w_add;
  logic [SW-1:0]        w_sum;
  logic [SW-1:0]        w_lk;
  logic [POT_W-1:0]     w_sat;
  logic                 w_odd;
  logic                 w_dev;
  logic                 w_refr;
  logic                 w_leak;
  logic                 w_fire;
  // Reset tied off so the tie-break sequence survives cell resets.
  lfsr u_lfsr (
    .clk   (clk),
    .reset (1'b0),
    .enable(1'b1),
    .lfsr  (w_rnd)
  );
  assign w_unused = &{1'b0, w_rnd[14:0]};
  // Direct hits and their mask; descending scan leaves the lowest-index hit winning.
  always_comb begin
    w_dmask = '0;
    w_hit   = '0;
    w_pri   = '0;
    for (int d = 0; d < DIRS; d++) begin
      w_dmask[direct_idx(d, DIRS)] = 1'b1;
      w_hit[d] = bus.in[direct_idx(d, DIRS)];
    end
    for (int d = DIRS - 1; d >= 0; d--)
      if (w_hit[d]) begin
        w_pri = '0;
        w_pri[(d + DIRS / 2) % DIRS] = 1'b1;
      end
  end
  assign w_col  = w_hit[DIRS/2-1:0] & w_hit[DIRS-1:DIRS/2];
  assign w_odd  = ^w_col;
  assign w_dev  = |w_hit;
  assign w_obl  = bus.in & ~w_dmask;
  assign w_c    = CW'($countones(w_obl));
  assign w_refr = r_ref != '0;
  assign w_leak = (LEAK_PER != 0) && (r_lk == LW'(LP1));
  // Integration is done wide so saturation and the zero floor are exact.
  assign w_add  = w_refr ? '0 : w_c;
  assign w_sum  = SW'(r_pot) + SW'(w_add);
  assign w_lk   = w_sum - SW'(w_leak && w_sum != '0);
  assign w_sat  = w_lk > PMAX ? {POT_W{1'b1}} : w_lk[POT_W-1:0];
  assign w_fire = !w_dev && !w_refr && w_sum >= SW'(THRESH);
  assign w_scat = DIRS'(scatter(w_rnd[15]));
  assign w_out  = w_odd ? '0 : w_dev ? w_pri : w_fire ? w_scat : '0;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_out  <= '0;
      r_fire <= 1'b0;
      r_pot  <= '0;
      r_ref  <= '0;
      r_lk   <= '0;
    end else if (bus.enable) begin
      r_out  <= w_out;
      r_fire <= w_fire;
      r_pot  <= w_fire ? '0 : w_sat;
      r_ref  <= w_fire ? RW'(REFRACT) : w_refr ? r_ref - 1'b1 : r_ref;
      r_lk   <= (w_leak || LEAK_PER == 0) ? '0 : r_lk + 1'b1;
    end else begin
      r_out  <= '0;
      r_fire <= 1'b0;
    end
  assign bus.out  = r_out & {DIRS{bus.enable}};
  assign bus.fire = r_fire & bus.enable;
  assign bus.pot  = r_pot;
endmodule
